// File: rtl/gray2bin_sync_pkg.sv
// Shared constants for the Gray pointer receiver.
// Optional step checking is enabled by defining GRAY_STEP_CHECK_EN.
package gray2bin_sync_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int WIDTH_MIN       = 2;
endpackage

// `define GRAY_STEP_CHECK_EN

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
module gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign binary_out[i] = ^gray_in[WIDTH-1:i];
  end

endmodule

// File: rtl/gray2bin_sync.sv
// Destination-domain receiver for a foreign Gray pointer: synchroniser, registered decode,
// advance delta and, with GRAY_STEP_CHECK_EN defined, a multi-bit-step violation flag.
module gray2bin_sync
  import gray2bin_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             ptr_changed,
  output logic [WIDTH-1:0] delta_out,
  output logic             step_err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("gray2bin_sync: SYNC_STAGES must be at least 2");
  end
  if (WIDTH < WIDTH_MIN) begin : g_bad_width
    $error("gray2bin_sync: WIDTH must be at least 2");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_gray;
  logic [WIDTH-1:0]                  dec;
  logic                              upd;

  // Plain flop chain: no logic between stages so each bit resolves metastability independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
  end

  assign gray_out = sync_q[SYNC_STAGES-1];
  assign upd      = (gray_out != prev_gray);

  gray2bin #(.WIDTH(WIDTH)) u_dec (
    .gray_in    (gray_out),
    .binary_out (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray   <= '0;
      bin_out     <= '0;
      delta_out   <= '0;
      ptr_changed <= 1'b0;
    end else begin
      ptr_changed <= upd;
      if (upd) begin
        prev_gray <= gray_out;
        bin_out   <= dec;
        delta_out <= dec - bin_out;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic             armed;
  logic [WIDTH-1:0] diff;

  assign diff = gray_out ^ prev_gray;

  // The first update after reset may legitimately jump several bits from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      step_err <= 1'b0;
    end else begin
      step_err <= upd && armed && ($countones(diff) > 1);
      if (upd) armed <= 1'b1;
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray2bin_sync.sv
// Self-checking bench for gray2bin_sync against a queue-based pointer model.
// Step-error expectations follow whether GRAY_STEP_CHECK_EN is defined.
module tb_gray2bin_sync;
  localparam int W = 4;
  localparam int S = 2;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] gray_out, bin_out, delta_out;
  logic         ptr_changed, step_err;

  int checks = 0;
  int errors = 0;

  gray2bin_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .gray_out    (gray_out),
    .bin_out     (bin_out),
    .ptr_changed (ptr_changed),
    .delta_out   (delta_out),
    .step_err    (step_err)
  );

  always #5 clk = ~clk;

  // Reference model: delay line of samples plus last-accepted pointer.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_prev, m_bin, m_delta, m_gout, m_g, m_nb;
  bit           m_chg, m_err, m_armed;

  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] to_gray(input int k);
    logic [W-1:0] b;
    b = k[W-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < S; i++) m_q.push_back('0);
    m_prev = '0; m_bin = '0; m_delta = '0; m_gout = '0;
    m_chg = 0; m_err = 0; m_armed = 0;
  endtask

  task automatic model_step();
    m_g = m_q[S-1];
    if (m_g != m_prev) begin
      m_nb    = to_bin(m_g);
      m_chg   = 1;
      m_err   = CHK && m_armed && ($countones(m_g ^ m_prev) > 1);
      m_delta = m_nb - m_bin;
      m_bin   = m_nb;
      m_prev  = m_g;
      m_armed = 1;
    end else begin
      m_chg = 0;
      m_err = 0;
    end
    m_q.push_front(gray_in);
    void'(m_q.pop_back());
    m_gout = m_q[S-1];
  endtask

  // One clock: model follows the edge, caller samples at the following negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !== '0) begin
      errors++;
      $display("FAIL reset_async: got g=%h b=%h chg=%b d=%h err=%b, want all 0",
               gray_out, bin_out, ptr_changed, delta_out, step_err);
    end
    gray_in = 4'b0101;
    repeat (3) cycle();
    checks++;
    if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !== '0) begin
      errors++;
      $display("FAIL reset_held: got g=%h b=%h chg=%b d=%h err=%b, want all 0",
               gray_out, bin_out, ptr_changed, delta_out, step_err);
    end
    gray_in = '0;
    rst = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_latency();
    gray_in = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      checks++;
      if (ptr_changed !== (e == 3) || bin_out !== ((e >= 3) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL latency_edge%0d: got chg=%b bin=%h, want chg=%b bin=%h",
                 e, ptr_changed, bin_out, (e == 3), (e >= 3) ? 4'd1 : 4'd0);
      end
      if (e == 3) begin
        checks++;
        if (delta_out !== 4'd1 || step_err !== 1'b0) begin
          errors++;
          $display("FAIL latency_delta: got d=%h err=%b, want d=1 err=0", delta_out, step_err);
        end
      end
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] seq[4];
    int pulses;
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    pulses = 0;
    foreach (seq[i]) begin
      gray_in = seq[i];
      repeat (4) begin
        cycle();
        if (ptr_changed) pulses++;
        checks++;
        if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !==
            {m_gout, m_bin, m_chg, m_delta, m_err} || step_err !== 1'b0 ||
            (ptr_changed && delta_out !== 4'd1)) begin
          errors++;
          $display("FAIL sequence: got g=%h b=%h chg=%b d=%h err=%b, want g=%h b=%h chg=%b d=%h err=0",
                   gray_out, bin_out, ptr_changed, delta_out, step_err,
                   m_gout, m_bin, m_chg, m_delta);
        end
      end
    end
    checks++;
    if (bin_out !== 4'd4 || pulses != 3) begin
      errors++;
      $display("FAIL sequence_end: got bin=%h pulses=%0d, want bin=4 pulses=3", bin_out, pulses);
    end
  endtask

  task automatic test_wrap();
    int hits;
    for (int k = 5; k <= 16; k++) begin
      gray_in = to_gray(k);
      hits = 0;
      repeat (4) begin
        cycle();
        checks++;
        if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !==
            {m_gout, m_bin, m_chg, m_delta, m_err}) begin
          errors++;
          $display("FAIL wrap_walk: got g=%h b=%h chg=%b d=%h err=%b, want g=%h b=%h chg=%b d=%h err=%b",
                   gray_out, bin_out, ptr_changed, delta_out, step_err,
                   m_gout, m_bin, m_chg, m_delta, m_err);
        end
        if (k == 16 && ptr_changed) begin
          hits++;
          checks++;
          if (bin_out !== 4'd0 || delta_out !== 4'd1 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_point: got b=%h d=%h err=%b, want b=0 d=1 err=0",
                     bin_out, delta_out, step_err);
          end
        end
      end
      if (k == 16) begin
        checks++;
        if (hits != 1) begin
          errors++;
          $display("FAIL wrap_pulse: got %0d pulses, want 1", hits);
        end
      end
    end
  endtask

  task automatic test_violation();
    gray_in = 4'b0001;
    repeat (4) cycle();
    gray_in = 4'b0010;
    repeat (3) cycle();
    checks++;
    if (ptr_changed !== 1'b1 || bin_out !== 4'd3 || delta_out !== 4'd2 || step_err !== CHK) begin
      errors++;
      $display("FAIL violation: got chg=%b b=%h d=%h err=%b, want chg=1 b=3 d=2 err=%b",
               ptr_changed, bin_out, delta_out, step_err, CHK);
    end
    cycle();
    checks++;
    if (step_err !== 1'b0 || ptr_changed !== 1'b0) begin
      errors++;
      $display("FAIL violation_pulse: got chg=%b err=%b next cycle, want 0 0", ptr_changed, step_err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    gray_in = 4'b0110;
    repeat (4) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got g=%h b=%h chg=%b d=%h err=%b, want all 0",
               gray_out, bin_out, ptr_changed, delta_out, step_err);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (ptr_changed) begin
        seen = 1;
        checks++;
        if (bin_out !== 4'd4 || delta_out !== 4'd4 || step_err !== 1'b0 || c != 2) begin
          errors++;
          $display("FAIL reset_rearm: got b=%h d=%h err=%b at edge %0d, want b=4 d=4 err=0 at edge 3",
                   bin_out, delta_out, step_err, c + 1);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL reset_rearm_timeout: got no ptr_changed in 10 cycles, want one");
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] b0, d0;
    b0 = bin_out;
    d0 = delta_out;
    repeat (20) begin
      cycle();
      checks++;
      if (ptr_changed !== 1'b0 || bin_out !== b0 || delta_out !== d0 || step_err !== 1'b0) begin
        errors++;
        $display("FAIL hold: got chg=%b b=%h d=%h err=%b, want chg=0 b=%h d=%h err=0",
                 ptr_changed, bin_out, delta_out, step_err, b0, d0);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] cur;
    int r;
    cur = gray_in;
    repeat (150) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       cur = to_gray(int'(to_bin(cur)) + 1);
      else if (r == 7) cur = W'($urandom);
      gray_in = cur;
      repeat ($urandom_range(1, 4)) begin
        cycle();
        checks++;
        if ({gray_out, bin_out, ptr_changed, delta_out, step_err} !==
            {m_gout, m_bin, m_chg, m_delta, m_err}) begin
          errors++;
          $display("FAIL random: got g=%h b=%h chg=%b d=%h err=%b, want g=%h b=%h chg=%b d=%h err=%b",
                   gray_out, bin_out, ptr_changed, delta_out, step_err,
                   m_gout, m_bin, m_chg, m_delta, m_err);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_sequence();
    test_wrap();
    test_violation();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
